// File: rtl/l2_ecc_err_monitor_if.sv
// Event, control and status bundle between the L2 memory wrapper and l2_ecc_err_monitor.
// The master side drives the error pulses and controls; the slave side is the monitor.
interface l2_ecc_err_monitor_if #(
   parameter int unsigned NumPort   = 2,
   parameter int unsigned AddrWidth = 48,
   parameter int unsigned CntWidth  = 16
);
   localparam int unsigned PortIdxWidth = (NumPort > 1) ? $clog2(NumPort) : 1;

   logic [NumPort-1:0]                corr_err_i;
   logic [NumPort-1:0]                uncorr_err_i;
   logic [NumPort-1:0][AddrWidth-1:0] err_addr_i;
   logic [CntWidth-1:0]               threshold_i;
   logic                              irq_ack_i;
   logic                              clear_i;
   logic [CntWidth-1:0]               corr_cnt_o;
   logic [CntWidth-1:0]               uncorr_cnt_o;
   logic                              first_valid_o;
   logic                              first_uncorr_o;
   logic [PortIdxWidth-1:0]           first_port_o;
   logic [AddrWidth-1:0]              first_addr_o;
   logic                              ecc_error_o;

   modport master (
      output corr_err_i, uncorr_err_i, err_addr_i, threshold_i, irq_ack_i, clear_i,
      input  corr_cnt_o, uncorr_cnt_o, first_valid_o, first_uncorr_o, first_port_o,
             first_addr_o, ecc_error_o
   );

   modport slave (
      input  corr_err_i, uncorr_err_i, err_addr_i, threshold_i, irq_ack_i, clear_i,
      output corr_cnt_o, uncorr_cnt_o, first_valid_o, first_uncorr_o, first_port_o,
             first_addr_o, ecc_error_o
   );
endinterface

// File: rtl/l2_ecc_err_monitor.sv
// L2 ECC error monitor: saturating error counters, sticky first-error record and level interrupt.
// Define L2_ECC_MON_ADDR_LOG_EN to build the first-error record; otherwise its outputs read 0.
module l2_ecc_err_monitor #(
   parameter int unsigned NumPort   = 2,
   parameter int unsigned AddrWidth = 48,
   parameter int unsigned CntWidth  = 16
) (
   input logic                clk_i,
   input logic                rst_i,
   l2_ecc_err_monitor_if.slave bus
);
   localparam int unsigned PortIdxWidth = (NumPort > 1) ? $clog2(NumPort) : 1;
   localparam int unsigned PopWidth     = $clog2(NumPort + 1);
   localparam int unsigned SumWidth     = CntWidth + PopWidth;
   localparam logic [CntWidth-1:0] CntMax = '1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ALERT = 2'd1,
      HOLD  = 2'd2
   } state_e;

   state_e              state_q;
   logic                ecc_error_q;
   logic [CntWidth-1:0] corr_cnt_q;
   logic [CntWidth-1:0] uncorr_cnt_q;

   logic [PopWidth-1:0] corr_pop_c;
   logic [PopWidth-1:0] uncorr_pop_c;
   logic [SumWidth-1:0] corr_sum_c;
   logic [SumWidth-1:0] uncorr_sum_c;
   logic [CntWidth-1:0] corr_next_c;
   logic [CntWidth-1:0] uncorr_next_c;
   logic                alert_c;

   function automatic logic [PopWidth-1:0] popcount(input logic [NumPort-1:0] v);
      logic [PopWidth-1:0] n;
      n = '0;
      for (int p = 0; p < int'(NumPort); p++) n = n + PopWidth'(v[p]);
      return n;
   endfunction

   // Post-update counts, widened so the sum cannot wrap before saturation.
   always_comb begin
      corr_pop_c    = popcount(bus.corr_err_i);
      uncorr_pop_c  = popcount(bus.uncorr_err_i);
      corr_sum_c    = SumWidth'(corr_cnt_q) + SumWidth'(corr_pop_c);
      uncorr_sum_c  = SumWidth'(uncorr_cnt_q) + SumWidth'(uncorr_pop_c);
      corr_next_c   = (corr_sum_c > SumWidth'(CntMax)) ? CntMax : corr_sum_c[CntWidth-1:0];
      uncorr_next_c = (uncorr_sum_c > SumWidth'(CntMax)) ? CntMax : uncorr_sum_c[CntWidth-1:0];
      alert_c       = (|bus.uncorr_err_i) ||
                      ((bus.threshold_i != '0) && (|bus.corr_err_i) &&
                       (corr_next_c >= bus.threshold_i));
   end

   // Counters and interrupt FSM; a new alert wins over a same-cycle ack.
   always_ff @(posedge clk_i) begin
      if (rst_i || bus.clear_i) begin
         state_q      <= IDLE;
         ecc_error_q  <= 1'b0;
         corr_cnt_q   <= '0;
         uncorr_cnt_q <= '0;
      end else begin
         corr_cnt_q   <= corr_next_c;
         uncorr_cnt_q <= uncorr_next_c;
         case (state_q)
            IDLE, HOLD: begin
               if (alert_c) begin
                  state_q     <= ALERT;
                  ecc_error_q <= 1'b1;
               end
            end
            ALERT: begin
               if (!alert_c && bus.irq_ack_i) begin
                  state_q     <= HOLD;
                  ecc_error_q <= 1'b0;
               end
            end
            default: begin
               state_q     <= IDLE;
               ecc_error_q <= 1'b0;
            end
         endcase
      end
   end

   assign bus.corr_cnt_o   = corr_cnt_q;
   assign bus.uncorr_cnt_o = uncorr_cnt_q;
   assign bus.ecc_error_o  = ecc_error_q;

`ifdef L2_ECC_MON_ADDR_LOG_EN
   logic                    first_valid_q;
   logic                    first_uncorr_q;
   logic [PortIdxWidth-1:0] first_port_q;
   logic [AddrWidth-1:0]    first_addr_q;

   logic                    sel_uncorr_c;
   logic [NumPort-1:0]      sel_vec_c;
   logic [PortIdxWidth-1:0] sel_port_c;

   // Uncorrectable events outrank correctable ones; lowest port index wins within a class.
   always_comb begin
      sel_uncorr_c = |bus.uncorr_err_i;
      sel_vec_c    = sel_uncorr_c ? bus.uncorr_err_i : bus.corr_err_i;
      sel_port_c   = '0;
      for (int p = int'(NumPort) - 1; p >= 0; p--) begin
         if (sel_vec_c[p]) sel_port_c = PortIdxWidth'(p);
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i || bus.clear_i) begin
         first_valid_q  <= 1'b0;
         first_uncorr_q <= 1'b0;
         first_port_q   <= '0;
         first_addr_q   <= '0;
      end else if (!first_valid_q && ((|bus.corr_err_i) || (|bus.uncorr_err_i))) begin
         first_valid_q  <= 1'b1;
         first_uncorr_q <= sel_uncorr_c;
         first_port_q   <= sel_port_c;
         first_addr_q   <= bus.err_addr_i[sel_port_c];
      end
   end

   assign bus.first_valid_o  = first_valid_q;
   assign bus.first_uncorr_o = first_uncorr_q;
   assign bus.first_port_o   = first_port_q;
   assign bus.first_addr_o   = first_addr_q;
`else
   logic unused_addr_c;

   assign unused_addr_c      = ^bus.err_addr_i;
   assign bus.first_valid_o  = 1'b0;
   assign bus.first_uncorr_o = 1'b0;
   assign bus.first_port_o   = '0;
   assign bus.first_addr_o   = '0;
`endif
endmodule

// File: tb/tb_l2_ecc_err_monitor.sv
// Randomized self-checking bench for l2_ecc_err_monitor against an event-level reference model.
// A 4-bit-counter instance runs the same stimulus to exercise saturation.
module tb_l2_ecc_err_monitor;
`ifdef L2_ECC_MON_ADDR_LOG_EN
   localparam bit LogEn = 1'b1;
`else
   localparam bit LogEn = 1'b0;
`endif

   logic clk;
   logic rst;
   int   n_tests;
   int   n_fail;

   l2_ecc_err_monitor_if #(.NumPort(2), .AddrWidth(48), .CntWidth(16)) bus_m ();
   l2_ecc_err_monitor_if #(.NumPort(2), .AddrWidth(48), .CntWidth(4))  bus_s ();

   l2_ecc_err_monitor #(.NumPort(2), .AddrWidth(48), .CntWidth(16)) u_dut (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (bus_m.slave)
   );

   l2_ecc_err_monitor #(.NumPort(2), .AddrWidth(48), .CntWidth(4)) u_dut_small (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (bus_s.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model state: index 0 = 16-bit instance, index 1 = 4-bit instance.
   longint      m_corr   [2];
   longint      m_uncorr [2];
   bit          m_irq    [2];
   bit          m_fv;
   bit          m_fu;
   int          m_fp;
   logic [47:0] m_fa;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model(input logic [1:0] c, input logic [1:0] u, input logic [47:0] a0,
                        input logic [47:0] a1, input logic [15:0] thr, input bit ack,
                        input bit clr);
      longint     mx;
      longint     th;
      bit         alert;
      logic [1:0] v;
      for (int i = 0; i < 2; i++) begin
         mx = (i == 0) ? 64'd65535 : 64'd15;
         th = (i == 0) ? longint'(thr) : longint'(thr[3:0]);
         if (clr) begin
            m_corr[i]   = 0;
            m_uncorr[i] = 0;
            m_irq[i]    = 1'b0;
         end else begin
            m_corr[i]   = m_corr[i] + $countones(c);
            m_uncorr[i] = m_uncorr[i] + $countones(u);
            if (m_corr[i] > mx) m_corr[i] = mx;
            if (m_uncorr[i] > mx) m_uncorr[i] = mx;
            alert = (u != 2'b00) || (th != 0 && c != 2'b00 && m_corr[i] >= th);
            if (alert) m_irq[i] = 1'b1;
            else if (ack) m_irq[i] = 1'b0;
         end
      end
      if (clr) begin
         m_fv = 1'b0;
         m_fu = 1'b0;
         m_fp = 0;
         m_fa = '0;
      end else if (!m_fv && (c | u) != 2'b00) begin
         m_fv = 1'b1;
         m_fu = (u != 2'b00);
         v    = m_fu ? u : c;
         m_fp = v[0] ? 0 : 1;
         m_fa = (m_fp == 0) ? a0 : a1;
      end
   endtask

   task automatic compare_all();
      check("corr_cnt",     64'(bus_m.corr_cnt_o),     64'(m_corr[0]));
      check("uncorr_cnt",   64'(bus_m.uncorr_cnt_o),   64'(m_uncorr[0]));
      check("ecc_error",    64'(bus_m.ecc_error_o),    64'(m_irq[0]));
      check("first_valid",  64'(bus_m.first_valid_o),  64'(LogEn ? m_fv : 1'b0));
      check("first_uncorr", 64'(bus_m.first_uncorr_o), 64'(LogEn ? m_fu : 1'b0));
      check("first_port",   64'(bus_m.first_port_o),   LogEn ? 64'(m_fp) : 64'd0);
      check("first_addr",   64'(bus_m.first_addr_o),   LogEn ? 64'(m_fa) : 64'd0);
      check("small_corr",   64'(bus_s.corr_cnt_o),     64'(m_corr[1]));
      check("small_uncorr", 64'(bus_s.uncorr_cnt_o),   64'(m_uncorr[1]));
      check("small_irq",    64'(bus_s.ecc_error_o),    64'(m_irq[1]));
   endtask

   // One clock cycle: drive inputs, let the edge pass, advance the model, compare.
   task automatic step(input logic [1:0] c, input logic [1:0] u, input logic [47:0] a0,
                       input logic [47:0] a1, input logic [15:0] thr, input bit ack,
                       input bit clr, input bit r);
      bus_m.corr_err_i   = c;
      bus_m.uncorr_err_i = u;
      bus_m.err_addr_i   = {a1, a0};
      bus_m.threshold_i  = thr;
      bus_m.irq_ack_i    = ack;
      bus_m.clear_i      = clr;
      bus_s.corr_err_i   = c;
      bus_s.uncorr_err_i = u;
      bus_s.err_addr_i   = {a1, a0};
      bus_s.threshold_i  = thr[3:0];
      bus_s.irq_ack_i    = ack;
      bus_s.clear_i      = clr;
      rst                = r;
      @(posedge clk);
      #1;
      model(c, u, a0, a1, thr, ack, clr | r);
      compare_all();
   endtask

   task automatic idle(input logic [15:0] thr);
      step(2'b00, 2'b00, 48'h0, 48'h0, thr, 1'b0, 1'b0, 1'b0);
   endtask

   initial begin
      logic [1:0]  c;
      logic [1:0]  u;
      logic [47:0] a0;
      logic [47:0] a1;
      logic [15:0] thr;
      n_tests = 0;
      n_fail  = 0;
      rst     = 1'b1;

      // Reset, then threshold 3 with three separated correctable pulses.
      step(2'b00, 2'b00, 48'h0, 48'h0, 16'd0, 1'b0, 1'b0, 1'b1);
      step(2'b00, 2'b00, 48'h0, 48'h0, 16'd0, 1'b0, 1'b0, 1'b1);
      check("reset_corr", 64'(bus_m.corr_cnt_o), 64'd0);
      check("reset_irq", 64'(bus_m.ecc_error_o), 64'd0);
      step(2'b01, 2'b00, 48'h10, 48'h0, 16'd3, 1'b0, 1'b0, 1'b0);
      idle(16'd3);
      step(2'b01, 2'b00, 48'h20, 48'h0, 16'd3, 1'b0, 1'b0, 1'b0);
      idle(16'd3);
      check("thr3_irq_before", 64'(bus_m.ecc_error_o), 64'd0);
      step(2'b01, 2'b00, 48'h30, 48'h0, 16'd3, 1'b0, 1'b0, 1'b0);
      check("thr3_cnt", 64'(bus_m.corr_cnt_o), 64'd3);
      check("thr3_irq_rise", 64'(bus_m.ecc_error_o), 64'd1);

      // Simultaneous events after a clear, then ack and re-alert.
      step(2'b00, 2'b00, 48'h0, 48'h0, 16'd0, 1'b0, 1'b1, 1'b0);
      step(2'b10, 2'b11, 48'h1000, 48'h2000, 16'd0, 1'b0, 1'b0, 1'b0);
      check("sim_uncorr", 64'(bus_m.uncorr_cnt_o), 64'd2);
      check("sim_corr", 64'(bus_m.corr_cnt_o), 64'd1);
      check("sim_first_addr", 64'(bus_m.first_addr_o), LogEn ? 64'h1000 : 64'd0);
      check("sim_irq", 64'(bus_m.ecc_error_o), 64'd1);
      step(2'b00, 2'b00, 48'h0, 48'h0, 16'd0, 1'b1, 1'b0, 1'b0);
      check("ack_irq_low", 64'(bus_m.ecc_error_o), 64'd0);
      idle(16'd0);
      step(2'b00, 2'b10, 48'h0, 48'h3000, 16'd0, 1'b0, 1'b0, 1'b0);
      check("realert_irq", 64'(bus_m.ecc_error_o), 64'd1);
      check("realert_addr_kept", 64'(bus_m.first_addr_o), LogEn ? 64'h1000 : 64'd0);
      // Ack coinciding with a new alert keeps the interrupt asserted.
      step(2'b00, 2'b01, 48'h4000, 48'h0, 16'd0, 1'b1, 1'b0, 1'b0);
      check("ack_vs_alert", 64'(bus_m.ecc_error_o), 64'd1);

      // Saturation of the 4-bit instance.
      step(2'b00, 2'b00, 48'h0, 48'h0, 16'd0, 1'b0, 1'b1, 1'b0);
      for (int k = 0; k < 10; k++) step(2'b11, 2'b00, 48'h55, 48'h66, 16'd0, 1'b0, 1'b0, 1'b0);
      check("sat_small", 64'(bus_s.corr_cnt_o), 64'd15);

      // Clear in the same cycle as an uncorrectable pulse.
      step(2'b00, 2'b01, 48'h77, 48'h0, 16'd0, 1'b0, 1'b1, 1'b0);
      check("clr_vs_evt_irq", 64'(bus_m.ecc_error_o), 64'd0);
      check("clr_vs_evt_cnt", 64'(bus_m.uncorr_cnt_o), 64'd0);

      // Threshold 0 disables correctable alerts.
      for (int k = 0; k < 20; k++) begin
         step(2'b01, 2'b00, 48'h88, 48'h0, 16'd0, 1'b0, 1'b0, 1'b0);
         idle(16'd0);
      end
      check("thr0_cnt", 64'(bus_m.corr_cnt_o), 64'd20);
      check("thr0_irq", 64'(bus_m.ecc_error_o), 64'd0);

      // Lowering the threshold below the count alone raises nothing.
      idle(16'd5);
      check("thr_lower_no_alert", 64'(bus_m.ecc_error_o), 64'd0);

      // Randomized traffic.
      thr = 16'd0;
      for (int k = 0; k < 3000; k++) begin
         if ($urandom_range(0, 49) == 0) thr = 16'($urandom_range(0, 40));
         c  = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b00;
         u  = ($urandom_range(0, 15) == 0) ? 2'($urandom) : 2'b00;
         a0 = {16'($urandom), 32'($urandom)};
         a1 = {16'($urandom), 32'($urandom)};
         step(c, u, a0, a1, thr, ($urandom_range(0, 9) == 0), ($urandom_range(0, 99) < 2),
              ($urandom_range(0, 299) == 0));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/l2_ecc_err_monitor.md
# l2_ecc_err_monitor

- Sits directly downstream of the L2 memory wrapper.
- Consumes per-port ECC error event pulses from the dynamic L2 memory and turns them into:
  - saturating correctable and uncorrectable error counters,
  - a sticky first-error address/port record,
  - the level `ecc_error_o` interrupt toward the carfield interrupt fabric.
- Drives the line that is currently tied low at the L2 wrapper boundary, with threshold, acknowledge and clear semantics.

## Interface
Parameters:
- `NumPort`, 2, number of L2 AXI ports producing error events.
- `AddrWidth`, 48, width of the reported error address.
- `CntWidth`, 16, width of each error counter.
- `PortIdxWidth`, `(NumPort > 1) ? $clog2(NumPort) : 1`, localparam, width of the port index field.

Ports:
- `clk_i`  in  1  sole clock.
- `rst_i`  in  1  reset; synchronous, active-high.
- `corr_err_i`  in  NumPort  single-cycle correctable-error pulse, one bit per port.
- `uncorr_err_i`  in  NumPort  single-cycle uncorrectable-error pulse, one bit per port.
- `err_addr_i`  in  NumPort×AddrWidth  address of the faulting access; valid while either pulse of that port is high.
- `threshold_i`  in  CntWidth  correctable-count alert threshold; 0 disables correctable alerts.
- `irq_ack_i`  in  1  single-cycle interrupt acknowledge.
- `clear_i`  in  1  single-cycle clear of all state.
- `corr_cnt_o`  out  CntWidth  correctable error count.
- `uncorr_cnt_o`  out  CntWidth  uncorrectable error count.
- `first_valid_o`  out  1  first-error record valid.
- `first_uncorr_o`  out  1  first recorded error was uncorrectable.
- `first_port_o`  out  PortIdxWidth  port of the first recorded error.
- `first_addr_o`  out  AddrWidth  address of the first recorded error.
- `ecc_error_o`  out  1  level interrupt.

## Operation
- **Counters**
  - On each cycle, `corr_cnt_o` += popcount(`corr_err_i`) and `uncorr_cnt_o` += popcount(`uncorr_err_i`).
  - Addition is performed at CntWidth+$clog2(NumPort+1) bits.
  - Result saturates at 2^CntWidth−1 and never wraps.
- **Both pulses on the same port in the same cycle:** the event counts in both counters.
- **First-error record**
  - Captured only when `first_valid_o`=0 and at least one pulse is high.
  - Selection priority: any uncorrectable error over any correctable error; then lowest port index.
  - Once captured, the record is held until `clear_i`; `irq_ack_i` does not affect it.
- **Alert condition (per cycle)**
  - any `uncorr_err_i` bit set, OR
  - `threshold_i`≠0, at least one `corr_err_i` bit set, and the post-update correctable count ≥ `threshold_i`.
- **Interrupt FSM**
  - IDLE (`ecc_error_o`=0) → ALERT on alert condition.
  - ALERT (`ecc_error_o`=1) → HOLD on `irq_ack_i`. An alert condition in the same cycle as the ack takes precedence and keeps the FSM in ALERT.
  - HOLD (`ecc_error_o`=0) → ALERT on alert condition.
- **`clear_i`**
  - From any state: FSM goes to IDLE; counters and the first-error record are zeroed.
  - Overrides same-cycle pulses and ack; those pulses are dropped, not counted.
- **`threshold_i` change:** sampled combinationally each cycle. Lowering it below the current count does not raise an alert by itself; an alert needs a new correctable pulse.

## Timing
- All outputs are registered.
- Reset values: all outputs 0; FSM in IDLE.
- Pulse in cycle N → counters, first-error record and `ecc_error_o` updated at the clock edge ending N, visible in N+1.
- `irq_ack_i` in N → `ecc_error_o` low in N+1, unless an alert condition occurs in N.
- `clear_i` in N → all outputs 0 in N+1.
- `rst_i` asserted mid-operation: identical effect to `clear_i` at the next edge, and takes priority over it.
- Pulses are level-sampled every cycle. A bit held high for k cycles counts k events.

## Configuration
- `L2_ECC_MON_ADDR_LOG_EN` defined:
  - first-error record implemented as described.
- Not defined:
  - no record registers are built;
  - `first_valid_o`, `first_uncorr_o`, `first_port_o` and `first_addr_o` are tied to 0;
  - counters and interrupt FSM are unchanged.

## Test plan
- **Reset:** after `rst_i`, all outputs 0. With `threshold_i`=3, pulse `corr_err_i`=2'b01 for 3 separate cycles → `corr_cnt_o`=3, and `ecc_error_o` rises exactly 1 cycle after the third pulse.
- **Simultaneous events:** `corr_err_i`=2'b10 and `uncorr_err_i`=2'b11 in one cycle, with addresses 0x1000 (port 0) and 0x2000 (port 1) → `uncorr_cnt_o`=2, `corr_cnt_o`=1, `first_uncorr_o`=1, `first_port_o`=0, `first_addr_o`=0x1000, `ecc_error_o`=1.
- **Ack and re-alert:** ack in ALERT → `ecc_error_o`=0 next cycle. A later `uncorr_err_i` pulse → `ecc_error_o`=1 again, and `first_addr_o` is unchanged.
- **Saturation:** with CntWidth=4, hold `corr_err_i`=2'b11 for 10 cycles → `corr_cnt_o` stops at 15.
- **Clear versus event:** `clear_i` in the same cycle as an `uncorr_err_i` pulse → next cycle all outputs 0 and the FSM is in IDLE.
- **Threshold 0:** with `threshold_i`=0, 20 correctable pulses → `ecc_error_o` stays 0 and `corr_cnt_o`=20.
